// File: rtl/bit_serializer.sv
// Parallel-to-serial shifter feeding the "11" pattern detector.
// A one-word holding register lets the next word start right after the current last bit.
module bit_serializer #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1,
   parameter bit IDLE_BIT  = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_in,
   input  logic             data_valid,
   output logic             data_ready,
   output logic             serial_bit,
   output logic             bit_active,
   output logic             word_done
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] SHIFT = 1'b1;

   logic [0:0]       state;
   logic [WIDTH-1:0] sh;
   logic [WIDTH-1:0] hold;
   logic [CW-1:0]    cnt;
   logic             hold_full;
   logic             last_bit;
   logic             free;
   logic             take;

   assign last_bit = (state == SHIFT) && (cnt == LAST);
   assign free     = (state == IDLE) || last_bit;
   assign take     = data_valid && !hold_full;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         sh        <= '0;
         cnt       <= '0;
         hold      <= '0;
         hold_full <= 1'b0;
      end else if (free) begin
         // A held word always wins; data_ready is low then, so no handshake can collide.
         if (hold_full) begin
            sh        <= hold;
            cnt       <= '0;
            state     <= SHIFT;
            hold_full <= 1'b0;
         end else if (take) begin
            sh    <= data_in;
            cnt   <= '0;
            state <= SHIFT;
         end else begin
            state <= IDLE;
         end
      end else begin
         sh  <= MSB_FIRST ? {sh[WIDTH-2:0], 1'b0} : {1'b0, sh[WIDTH-1:1]};
         cnt <= cnt + CW'(1);
         if (take) begin
            hold      <= data_in;
            hold_full <= 1'b1;
         end
      end
   end

   assign data_ready = !hold_full;
   assign bit_active = (state == SHIFT);
   assign word_done  = last_bit;
   assign serial_bit = (state == SHIFT) ? (MSB_FIRST ? sh[WIDTH-1] : sh[0]) : IDLE_BIT;

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: MSB-first and LSB-first instances share one input stream and are
// compared every cycle against a word-schedule model; a small "11" detector rides on the MSB output.
module tb_bit_serializer;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         data_valid = 1'b0;
   logic [W-1:0] data_in = '0;
   logic         rdy_m, ser_m, act_m, done_m;
   logic         rdy_l, ser_l, act_l, done_l;
   logic         det_prev, det;

   int checks = 0;
   int errors = 0;
   int e = 0;

   // Accepted word: data, acceptance edge, first sample carrying its first bit.
   typedef struct {
      logic [W-1:0] d;
      int           acc;
      int           st;
   } word_t;
   word_t words[$];

   bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
      .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
      .data_ready(rdy_m), .serial_bit(ser_m), .bit_active(act_m), .word_done(done_m));

   bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
      .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
      .data_ready(rdy_l), .serial_bit(ser_l), .bit_active(act_l), .word_done(done_l));

   always #5 clk = ~clk;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         det_prev <= 1'b0;
         det      <= 1'b0;
      end else begin
         det_prev <= ser_m;
         det      <= det_prev & ser_m;
      end
   end

   // Expected {act,bit,done,ready} for MSB then LSB instance at sample n (sample n follows edge n).
   function automatic logic [7:0] model(input int n);
      logic a = 1'b0, bm = 1'b0, bl = 1'b0, dn = 1'b0, r = 1'b1;
      int idx;
      foreach (words[i]) begin
         if (n >= words[i].st && n < words[i].st + W) begin
            a   = 1'b1;
            idx = n - words[i].st;
            bm  = words[i].d[W-1-idx];
            bl  = words[i].d[idx];
            dn  = (idx == W - 1);
         end
         if (n >= words[i].acc && n < words[i].st) r = 1'b0;
      end
      return {a, bm, dn, r, a, bl, dn, r};
   endfunction

   task automatic step(input logic v, input logic [W-1:0] d,
                       output logic [7:0] obs, output logic [7:0] exp_v, output int n);
      logic [7:0] prev;
      int last_end, st;
      data_valid = v;
      data_in    = d;
      prev = model(e - 1);
      @(posedge clk);
      if (v && prev[0]) begin
         last_end = (words.size() > 0) ? words[$].st + W - 1 : -1000;
         st = (e > last_end + 1) ? e : last_end + 1;
         words.push_back('{d: d, acc: e, st: st});
      end
      @(negedge clk);
      obs   = {act_m, ser_m, done_m, rdy_m, act_l, ser_l, done_l, rdy_l};
      exp_v = model(e);
      n     = e;
      e++;
   endtask

   task automatic test_reset();
      logic [7:0] obs;
      #1;
      obs = {act_m, ser_m, done_m, rdy_m, act_l, ser_l, done_l, rdy_l};
      checks++;
      if (obs !== 8'b0001_0001) begin
         errors++;
         $display("FAIL reset_state: got %b want %b", obs, 8'b0001_0001);
      end
      data_valid = 1'b1;
      data_in    = 8'hC3;
      @(posedge clk);
      @(negedge clk);
      obs = {act_m, ser_m, done_m, rdy_m, act_l, ser_l, done_l, rdy_l};
      checks++;
      if (obs !== 8'b0001_0001) begin
         errors++;
         $display("FAIL reset_ignores_handshake: got %b want %b", obs, 8'b0001_0001);
      end
      data_valid = 1'b0;
      reset      = 1'b0;
      e          = 0;
   endtask

   task automatic idle_run(input int cycles, input string name);
      logic [7:0] obs, ex;
      int n;
      for (int i = 0; i < cycles; i++) begin
         step(1'b0, W'($urandom), obs, ex, n);
         checks++;
         if (obs !== ex) begin
            errors++;
            $display("FAIL %s sample %0d: got %b want %b", name, n, obs, ex);
         end
      end
   endtask

   task automatic test_single();
      logic [7:0] obs, ex;
      logic [W-1:0] got = '0;
      int n, s0, dones = 0;
      step(1'b1, 8'hB2, obs, ex, n);
      s0 = words[$].st;
      checks++;
      if (obs !== ex) begin
         errors++;
         $display("FAIL single sample %0d: got %b want %b", n, obs, ex);
      end
      for (int i = 0; i < W + 3; i++) begin
         if (n >= s0 && n < s0 + W) got = {got[W-2:0], obs[6]};
         if (obs[5]) dones++;
         step(1'b0, W'($urandom), obs, ex, n);
         checks++;
         if (obs !== ex) begin
            errors++;
            $display("FAIL single sample %0d: got %b want %b", n, obs, ex);
         end
      end
      checks++;
      if (got !== 8'hB2 || dones != 1) begin
         errors++;
         $display("FAIL single_word: got bits %h done_count %0d want bits b2 done_count 1", got, dones);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] obs, ex;
      int n, act_cnt = 0;
      step(1'b1, 8'hFF, obs, ex, n);
      if (obs[7]) act_cnt++;
      checks++;
      if (obs !== ex) begin
         errors++;
         $display("FAIL b2b sample %0d: got %b want %b", n, obs, ex);
      end
      step(1'b1, 8'h0F, obs, ex, n);
      if (obs[7]) act_cnt++;
      checks++;
      if (obs !== ex) begin
         errors++;
         $display("FAIL b2b sample %0d: got %b want %b", n, obs, ex);
      end
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 8'hA5, obs, ex, n);
         if (obs[7]) act_cnt++;
         checks++;
         if (obs !== ex) begin
            errors++;
            $display("FAIL b2b sample %0d: got %b want %b", n, obs, ex);
         end
      end
      for (int i = 0; i < 18; i++) begin
         step(1'b0, W'($urandom), obs, ex, n);
         if (obs[7]) act_cnt++;
         checks++;
         if (obs !== ex) begin
            errors++;
            $display("FAIL b2b sample %0d: got %b want %b", n, obs, ex);
         end
      end
      checks++;
      if (act_cnt != 3 * W) begin
         errors++;
         $display("FAIL b2b_active_count: got %0d want %0d", act_cnt, 3 * W);
      end
   endtask

   task automatic test_reset_mid_word();
      logic [7:0] obs, ex;
      int n;
      step(1'b1, 8'hFF, obs, ex, n);
      step(1'b1, 8'h0F, obs, ex, n);
      step(1'b0, 8'h00, obs, ex, n);
      step(1'b0, 8'h00, obs, ex, n);
      checks++;
      if (obs !== ex) begin
         errors++;
         $display("FAIL reset_mid_pre sample %0d: got %b want %b", n, obs, ex);
      end
      #2 reset = 1'b1;
      #1;
      obs = {act_m, ser_m, done_m, rdy_m, act_l, ser_l, done_l, rdy_l};
      checks++;
      if (obs !== 8'b0001_0001) begin
         errors++;
         $display("FAIL reset_async_immediate: got %b want %b", obs, 8'b0001_0001);
      end
      data_valid = 1'b1;
      data_in    = 8'h3C;
      @(posedge clk);
      e++;
      @(negedge clk);
      reset      = 1'b0;
      data_valid = 1'b0;
      words.delete();
      step(1'b1, 8'h80, obs, ex, n);
      checks++;
      if (obs !== ex || obs[6] !== 1'b1) begin
         errors++;
         $display("FAIL reset_next_word sample %0d: got %b want %b", n, obs, ex);
      end
      idle_run(W + 2, "reset_next_word");
   endtask

   task automatic test_lsb_first();
      logic [7:0] obs, ex;
      int n;
      step(1'b1, 8'h01, obs, ex, n);
      checks++;
      if (obs !== ex || obs[2] !== 1'b1) begin
         errors++;
         $display("FAIL lsb_first sample %0d: got %b want %b", n, obs, ex);
      end
      idle_run(W + 2, "lsb_first");
   endtask

   task automatic test_detector_chain();
      logic [7:0] obs, ex;
      logic exp_det;
      int n, s0 = 0, pulses = 0, pulse_at = -1;
      for (int i = 0; i < W + 5; i++) begin
         step(i == 0, (i == 0) ? 8'b0110_0000 : W'($urandom), obs, ex, n);
         if (i == 0) s0 = words[$].st;
         exp_det = model(n - 1)[6] & model(n - 2)[6];
         checks++;
         if (obs !== ex || det !== exp_det) begin
            errors++;
            $display("FAIL detector sample %0d: got %b det %b want %b det %b", n, obs, det, ex, exp_det);
         end
         if (det === 1'b1) begin
            pulses++;
            pulse_at = n;
         end
      end
      checks++;
      if (pulses != 1 || pulse_at != s0 + 3) begin
         errors++;
         $display("FAIL detector_pulse: got %0d pulses at offset %0d want 1 at offset 3", pulses, pulse_at - s0);
      end
   endtask

   task automatic test_random();
      logic [7:0] obs, ex;
      int n;
      for (int i = 0; i < 400; i++) begin
         step(($urandom % 4) != 0, W'($urandom), obs, ex, n);
         checks++;
         if (obs !== ex) begin
            errors++;
            $display("FAIL random sample %0d: got %b want %b", n, obs, ex);
         end
      end
      idle_run(2 * W + 2, "random_drain");
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_reset_mid_word();
      test_lsb_first();
      test_detector_chain();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
